// File: rtl/bus_master_6502.sv
// bus_master_6502: runs valid/ready requests as 6502-style PHI2/RW/A/D bus cycles, honouring RDY on reads.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata request side;
// rsp_valid/rsp_rdata/rsp_err completion side; PHI2/RW/A/D_out/D_oe/D_in/RDY 6502 bus side.
module bus_master_6502 #(
    parameter int          LOW_CLKS  = 2,
    parameter int          HIGH_CLKS = 2,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF,
    parameter int          STALL_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        PHI2,
    output logic        RW,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    input  logic        RDY
);
    localparam int CW = $clog2(LOW_CLKS + HIGH_CLKS + 1);
    localparam int SW = $clog2(STALL_MAX + 1);
    typedef enum logic {PH1, PH2} ph_t;
    ph_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] stall_cnt;
    logic pend, pend_wr, cur_act, cur_wr;
    logic [15:0] pend_addr;
    logic [7:0] pend_wdata;
    logic ph1_end, boundary, accept, rd_cur, stall_rep, done, bypass;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PH1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        ph1_end   = state == PH1 && cnt == CW'(LOW_CLKS - 1);
        boundary  = state == PH2 && cnt == CW'(HIGH_CLKS - 1);
        state_nxt = ph1_end ? PH2 : boundary ? PH1 : state;
        cnt_nxt   = (ph1_end || boundary) ? '0 : cnt + 1'b1;
    end
    // A stalled read keeps the bus; a new request only launches on a boundary if nothing else owns it.
    always_comb begin
        req_ready = !pend && !rst;
        accept    = req_valid && req_ready;
        rd_cur    = cur_act && !cur_wr;
        stall_rep = rd_cur && !RDY && stall_cnt < SW'(STALL_MAX);
        done      = cur_act && !stall_rep;
        bypass    = boundary && accept && !stall_rep;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            PHI2 <= 1'b0;
            RW <= 1'b1;
            A <= IDLE_ADDR;
            D_out <= 8'h00;
            D_oe <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err <= 1'b0;
            pend <= 1'b0;
            pend_wr <= 1'b0;
            pend_addr <= '0;
            pend_wdata <= '0;
            cur_act <= 1'b0;
            cur_wr <= 1'b0;
            stall_cnt <= '0;
        end else begin
            PHI2 <= state_nxt == PH2;
            D_oe <= state_nxt == PH2 && cur_act && cur_wr;
            rsp_valid <= boundary && done;
            if (boundary && done) begin
                rsp_rdata <= cur_wr ? 8'h00 : RDY ? D_in : 8'hFF;
                rsp_err <= rd_cur && !RDY;
            end
            if (accept && !bypass) begin
                pend <= 1'b1;
                pend_wr <= req_write;
                pend_addr <= req_addr;
                pend_wdata <= req_wdata;
            end else if (boundary && !stall_rep) begin
                pend <= 1'b0;
            end
            if (boundary) begin
                stall_cnt <= stall_rep ? stall_cnt + 1'b1 : '0;
                if (!stall_rep) begin
                    cur_act <= pend || accept;
                    cur_wr <= pend ? pend_wr : accept && req_write;
                    A <= pend ? pend_addr : accept ? req_addr : IDLE_ADDR;
                    RW <= pend ? !pend_wr : accept ? !req_write : 1'b1;
                    D_out <= pend ? pend_wdata : accept ? req_wdata : 8'h00;
                end
            end
        end
    end
endmodule

// File: doc/bus_master_6502.md
Name: bus_master_6502

Overview:
- Synthesizes 6502-style bus cycles (PHI2, RW, A, D) from a simple valid/ready request interface inside the FPGA.
- Used for debug/DMA access to memory and peripherals behind the on-board chip_select decoders.
- Generates a free-running PHI2 and runs one request per bus cycle.
- Honours RDY wait states on reads and reports a timeout error.

Parameters:
- LOW_CLKS, 2: clk cycles per PHI1 phase (PHI2 low), >=1.
- HIGH_CLKS, 2: clk cycles per PHI2-high phase, >=1.
- IDLE_ADDR, 16'hFFFF: address driven on idle bus cycles.
- STALL_MAX, 8: consecutive RDY-low read repeats before forced completion with error, >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this clk when req_valid & req_ready
- req_write  in  1  1 = write cycle, 0 = read cycle
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clk completion pulse
- rsp_rdata  out  8  read data; 8'h00 for writes
- rsp_err  out  1  completion was a RDY timeout
- PHI2  out  1  bus phase-2 clock
- RW  out  1  1 = read, 0 = write
- A  out  16  bus address
- D_out  out  8  write data
- D_oe  out  1  data bus drive enable
- D_in  in  8  data bus input
- RDY  in  1  responder ready; low stretches read cycles

Behaviour:
- **Clock and reset.** Single clock; reset is synchronous and active-high on rst. All outputs are registered except req_ready.
- **Reset values:**
  - PHI2=0, RW=1, A=IDLE_ADDR, D_out=0, D_oe=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - pending buffer empty, stall count 0
  - phase FSM in PH1 with count 0
  - req_ready=0 while rst is high.
- **Phase FSM.** States PH1 and PH2, with a phase counter.
  - PH1 lasts LOW_CLKS clks with PHI2=0.
  - PH2 lasts HIGH_CLKS clks with PHI2=1.
  - PHI2 toggles continuously, including when idle.
- **Boundary clock.** The last clk of PH2. Every bus cycle begins on the clk after a boundary.
- **Request buffer.** One entry.
  - req_ready = !pend & !rst.
  - An accept at any clk loads pend.
  - Bypass: an accept on a boundary clk with pend empty launches directly on that boundary and does not set pend.
- **Launch at boundary.** Priority order:
  - repeat the stalled read;
  - else pend (clear it);
  - else a bypassed new request;
  - else an idle cycle.
- **Per-cycle outputs.** A, RW and D_out update on the first PH1 clk and are held for the whole cycle, including repeats.
  - Idle cycle: RW=1, A=IDLE_ADDR, no response.
- **Writes.**
  - D_oe=1 for all PH2 clks of the write cycle, 0 elsewhere.
  - RDY is ignored.
  - Completion: rsp_valid pulses on the clk after the boundary with rsp_rdata=0 and rsp_err=0.
- **Reads.** D_oe=0. D_in and RDY are sampled on the boundary clk.
  - RDY=1: rsp_valid pulses next clk with rsp_rdata=sampled D_in, rsp_err=0. Stall count resets.
  - RDY=0 and stall count < STALL_MAX: increment the count and repeat the identical cycle. No response.
  - RDY=0 and stall count == STALL_MAX: complete with rsp_rdata=8'hFF, rsp_err=1. Stall count resets.
  - Total bus cycles for a timed-out read: STALL_MAX+1.
- **Response hold.** rsp_rdata and rsp_err hold until the next completion. rsp_valid is exactly one clk wide.
- **Latency.** With LOW=HIGH=2, from an accept on the clk just before a boundary (pend set, launched at that boundary), rsp_valid asserts 5 clks later.
- **Throughput.** Sustained throughput is one request per bus cycle.
- **Reset mid-cycle.** Any in-flight or pending request is dropped with no response. The FSM restarts in PH1.

Test Plan:
1. **Reset/idle.** Hold rst 3 clks, then release with no requests.
   - Every output matches its reset value during rst.
   - Released: PHI2 pattern 0,0,1,1 repeating, RW=1, A=16'hFFFF, D_oe=0, and rsp_valid never asserts.
2. **Single write.** Write to 16'h8001 with data 8'h5A.
   - Next bus cycle: A=16'h8001, RW=0.
   - D_out=8'h5A with D_oe=1 only during the PHI2-high clks.
   - rsp_valid pulses once, rsp_err=0.
3. **Single read.** Read 16'h8002 with D_in=8'hC3 and RDY=1.
   - rsp_valid pulses once with rsp_rdata=8'hC3.
   - The bus returns to an idle cycle afterwards.
4. **RDY stretch.** Read 16'h4000 with RDY=0 on the first 3 boundaries, then 1, and D_in=8'h11.
   - A stays 16'h4000 for 4 bus cycles.
   - A single rsp_valid with 8'h11, rsp_err=0.
5. **Timeout.** Read with RDY held 0 and STALL_MAX=8.
   - Completes after 9 bus cycles with rsp_rdata=8'hFF, rsp_err=1.
   - The next queued request then runs normally.
6. **Back-to-back and reset.**
   - req_valid held high for 4 writes: one bus cycle each, req_ready drops while pend is full, and 4 responses in order.
   - Assert rst mid-PH2 of a read: no response, and outputs return to their reset values on the next clk.
